coefficient_window_subsystem: RTL and testbench
===============================================

# coefficient_window_subsystem

Coefficient/logging memory-window subsystem. Two 16-bit SBUS Wishbone slave windows share one 2048×16 dual-port block RAM:
- The coefficient window writes the RAM through an auto-incrementing address pointer.
- The logging window reads the RAM through its own auto-incrementing pointer, on the port normally used by the biquad engine.

Internally it is three blocks: coefficient_memwindow, coefficient_blockram and logging_memwindow.

## Interface
Parameters:
- ADDR_W, 11: RAM address width (depth 2^ADDR_W).
- DATA_W, 16: RAM and bus data width.
- PTR_REG, 16'h003C: SBUS address of the pointer register in each window.
- DATA_REG, 16'h003E: SBUS address of the data register in each window.

Ports:
- wb_clk_i  in  1  single system clock; all logic on the rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-low.
- coef_wb_cyc_i, coef_wb_stb_i, coef_wb_we_i  in  1 each  coefficient window Wishbone controls.
- coef_wb_adr_i  in  16  coefficient window address.
- coef_wb_sel_i  in  2  byte selects; ignored, all accesses are 16-bit.
- coef_wb_dat_i  in  16  coefficient window write data.
- coef_wb_dat_o  out  16  coefficient window read data.
- coef_wb_ack_o  out  1  coefficient window acknowledge.
- log_wb_cyc_i, log_wb_stb_i, log_wb_we_i  in  1 each  logging window Wishbone controls.
- log_wb_adr_i  in  16  logging window address.
- log_wb_sel_i  in  2  ignored.
- log_wb_dat_i  in  16  logging window write data (pointer only).
- log_wb_dat_o  out  16  logging window read data.
- log_wb_ack_o  out  1  logging window acknowledge.

## Operation
Each window owns an 11-bit pointer and a three-state FSM: IDLE, ACK, HOLD.

Access start:
- An access starts in IDLE when cyc&stb is sampled high at a clock edge.
- At that edge the window performs the action and moves to ACK.

ACK state:
- ack_o=1 and dat_o is valid for exactly one cycle.
- At the end of ACK, the pointer increments when the access was to DATA_REG and the increment rule below applies.
- Next state is HOLD if cyc&stb is still high, otherwise IDLE.

HOLD state:
- Stays in HOLD until cyc or stb drops, then returns to IDLE.
- Exactly one access and one ack occur per stb assertion, however long stb is held.

Coefficient window:
- Write PTR_REG: ptr := dat_i[10:0].
- Read PTR_REG: dat_o = {5'b0, ptr}.
- Write DATA_REG: mem[ptr] := dat_i; ptr increments.
- Read DATA_REG: dat_o = 16'h0000 and no increment, because the coefficient RAM port is write-only.

Logging window:
- PTR_REG write and read behave as in the coefficient window.
- Read DATA_REG: RAM read at ptr, registered at the start edge; dat_o = mem[ptr] during ACK; ptr increments.
- Write DATA_REG: acknowledged, no effect, no increment.

Other addresses: acknowledged; writes ignored; reads return 16'h0000; pointer unchanged.

RAM:
- Write port is driven by the coefficient window only; read port by the logging window only.
- Each port acknowledges one cycle after its strobe.
- A read and a write to the same address at the same edge returns the old data.
- Contents are not cleared by reset; simulation initialises them to 0.

Pointer arithmetic: 11-bit; 0x7FF+1 wraps to 0x000.

Simultaneous coefficient and logging accesses are independent and both complete with no stall.

## Timing
- Reset (wb_rst_i=0, asynchronous): both FSMs go to IDLE and both pointers to 0x000. coef_wb_ack_o, log_wb_ack_o, coef_wb_dat_o and log_wb_dat_o go to 0. Any in-flight access is aborted with no ack and no increment.
- Latency: ack is high in the second cycle of cyc&stb (one wait state) for every register. A master holding stb for 2 cycles completes one access.
- dat_o is held at its last value outside ACK; it is only valid while ack_o=1.
- A RAM write is visible to a logging read whose start edge is at least one cycle after the write's start edge.
- Back-to-back accesses need at least one IDLE cycle between stb assertions, because HOLD or ACK must return to IDLE first.

## Test plan
- Reset, then coefficient write PTR_REG=0x5555, then read PTR_REG -> dat_o=0x0555 with ack high for exactly one cycle.
- Coefficient write DATA_REG=0xAAAA, then DATA_REG=0xBBBB (stb held 2 cycles each) -> mem[0x555]=0xAAAA, mem[0x556]=0xBBBB, coefficient ptr=0x557.
- Logging write PTR_REG=0x5555, then read DATA_REG twice -> 0xAAAA then 0xBBBB; logging ptr=0x557. A logging write to DATA_REG changes nothing.
- Pointer=0x7FF, write DATA_REG=0x1234 -> mem[0x7FF]=0x1234, pointer wraps to 0x000. Holding stb for 5 cycles -> still one ack, one increment.
- Assert wb_rst_i low during ACK of a DATA_REG write -> ack drops immediately, pointer=0x000, no increment.
- Concurrent coefficient write of 0xCAFE to address A and logging read of address A at the same edge -> the read returns the old value; a read one cycle later returns 0xCAFE.

Source files
------------

// File: rtl/coefficient_window_subsystem.sv
// Coefficient/logging memory-window subsystem: two SBUS Wishbone slave windows
// sharing one dual-port block RAM (coefficient window writes, logging window reads).

package coefficient_window_pkg;
  typedef enum logic [1:0] {IDLE, ACK, HOLD} win_state_e;
endpackage

module coefficient_blockram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto block RAM; only the read register is reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Same-address read and write at one edge returns the old word (read-before-write).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

module coefficient_memwindow
  import coefficient_window_pkg::*;
#(
  parameter int          ADDR_W   = 11,
  parameter int          DATA_W   = 16,
  parameter logic [15:0] PTR_REG  = 16'h003C,
  parameter logic [15:0] DATA_REG = 16'h003E
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [15:0]       adr_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic [DATA_W-1:0] dat_o,
  output logic              ack_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o
);
  win_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              inc_q, inc_d;
  logic              req, start;

  assign req = cyc_i & stb_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = ACK;
      ACK:     state_d = req ? HOLD : IDLE;
      HOLD:    if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_o = (state_q == ACK);
    start = (state_q == IDLE) && req;
  end

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    ptr_d    = ptr_q;
    dat_d    = dat_q;
    inc_d    = inc_q;
    ram_we_o = 1'b0;
    if (start) begin
      inc_d = 1'b0;
      dat_d = '0;
      if (adr_i == PTR_REG) begin
        if (we_i) ptr_d = dat_i[ADDR_W-1:0];
        else      dat_d = {{(DATA_W-ADDR_W){1'b0}}, ptr_q};
      end else if (adr_i == DATA_REG && we_i) begin
        ram_we_o = 1'b1;
        inc_d    = 1'b1;
      end
    end else if (ack_o && inc_q) begin
      ptr_d = ptr_q + ADDR_W'(1);
    end
  end

  // NOTE: sequential state is assigned with non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      dat_q <= '0;
      inc_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      dat_q <= dat_d;
      inc_q <= inc_d;
    end
  end

  assign dat_o       = dat_q;
  assign ram_addr_o  = ptr_q;
  assign ram_wdata_o = dat_i;
endmodule

module logging_memwindow
  import coefficient_window_pkg::*;
#(
  parameter int          ADDR_W   = 11,
  parameter int          DATA_W   = 16,
  parameter logic [15:0] PTR_REG  = 16'h003C,
  parameter logic [15:0] DATA_REG = 16'h003E
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [15:0]       adr_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic [DATA_W-1:0] dat_o,
  output logic              ack_o,
  output logic              ram_re_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);
  win_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              inc_q, inc_d;
  logic              rsel_q, rsel_d;
  logic              req, start;
  logic              unused_dat;

  assign req        = cyc_i & stb_i;
  assign unused_dat = ^dat_i[DATA_W-1:ADDR_W];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = ACK;
      ACK:     state_d = req ? HOLD : IDLE;
      HOLD:    if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_o = (state_q == ACK);
    start = (state_q == IDLE) && req;
  end

  always_comb begin
    ptr_d    = ptr_q;
    dat_d    = dat_q;
    inc_d    = inc_q;
    rsel_d   = rsel_q;
    ram_re_o = 1'b0;
    if (start) begin
      inc_d  = 1'b0;
      rsel_d = 1'b0;
      dat_d  = '0;
      if (adr_i == PTR_REG) begin
        if (we_i) ptr_d = dat_i[ADDR_W-1:0];
        else      dat_d = {{(DATA_W-ADDR_W){1'b0}}, ptr_q};
      end else if (adr_i == DATA_REG && !we_i) begin
        ram_re_o = 1'b1;
        rsel_d   = 1'b1;
        inc_d    = 1'b1;
      end
    end else if (ack_o && inc_q) begin
      ptr_d = ptr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= '0;
      dat_q  <= '0;
      inc_q  <= 1'b0;
      rsel_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      dat_q  <= dat_d;
      inc_q  <= inc_d;
      rsel_q <= rsel_d;
    end
  end

  // The RAM read register only changes on a read strobe, so it holds between accesses.
  assign dat_o      = rsel_q ? ram_rdata_i : dat_q;
  assign ram_addr_o = ptr_q;
endmodule

module coefficient_window_subsystem #(
  parameter int          ADDR_W   = 11,
  parameter int          DATA_W   = 16,
  parameter logic [15:0] PTR_REG  = 16'h003C,
  parameter logic [15:0] DATA_REG = 16'h003E
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              coef_wb_cyc_i,
  input  logic              coef_wb_stb_i,
  input  logic              coef_wb_we_i,
  input  logic [15:0]       coef_wb_adr_i,
  input  logic [1:0]        coef_wb_sel_i,
  input  logic [DATA_W-1:0] coef_wb_dat_i,
  output logic [DATA_W-1:0] coef_wb_dat_o,
  output logic              coef_wb_ack_o,
  input  logic              log_wb_cyc_i,
  input  logic              log_wb_stb_i,
  input  logic              log_wb_we_i,
  input  logic [15:0]       log_wb_adr_i,
  input  logic [1:0]        log_wb_sel_i,
  input  logic [DATA_W-1:0] log_wb_dat_i,
  output logic [DATA_W-1:0] log_wb_dat_o,
  output logic              log_wb_ack_o
);
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              unused_sel;

  assign unused_sel = ^{coef_wb_sel_i, log_wb_sel_i};

  coefficient_memwindow #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PTR_REG(PTR_REG), .DATA_REG(DATA_REG)
  ) u_coef (
    .clk_i(wb_clk_i), .rst_ni(wb_rst_i),
    .cyc_i(coef_wb_cyc_i), .stb_i(coef_wb_stb_i), .we_i(coef_wb_we_i),
    .adr_i(coef_wb_adr_i), .dat_i(coef_wb_dat_i),
    .dat_o(coef_wb_dat_o), .ack_o(coef_wb_ack_o),
    .ram_we_o(ram_we), .ram_addr_o(ram_waddr), .ram_wdata_o(ram_wdata)
  );

  coefficient_blockram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk_i(wb_clk_i), .rst_ni(wb_rst_i),
    .we_i(ram_we), .waddr_i(ram_waddr), .wdata_i(ram_wdata),
    .re_i(ram_re), .raddr_i(ram_raddr), .rdata_o(ram_rdata)
  );

  logging_memwindow #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PTR_REG(PTR_REG), .DATA_REG(DATA_REG)
  ) u_log (
    .clk_i(wb_clk_i), .rst_ni(wb_rst_i),
    .cyc_i(log_wb_cyc_i), .stb_i(log_wb_stb_i), .we_i(log_wb_we_i),
    .adr_i(log_wb_adr_i), .dat_i(log_wb_dat_i),
    .dat_o(log_wb_dat_o), .ack_o(log_wb_ack_o),
    .ram_re_o(ram_re), .ram_addr_o(ram_raddr), .ram_rdata_i(ram_rdata)
  );
endmodule

// File: tb/tb_coefficient_window_subsystem.sv
// Directed bench for coefficient_window_subsystem: expected read data is queued per
// window when an access is issued and popped when that window acknowledges.

module tb_coefficient_window_subsystem;
  localparam logic [15:0] PTR  = 16'h003C;
  localparam logic [15:0] DATA = 16'h003E;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        coef_cyc = 0, coef_stb = 0, coef_we = 0;
  logic [15:0] coef_adr = '0, coef_dat_i = '0;
  logic [15:0] coef_dat_o;
  logic        coef_ack;
  logic        log_cyc = 0, log_stb = 0, log_we = 0;
  logic [15:0] log_adr = '0, log_dat_i = '0;
  logic [15:0] log_dat_o;
  logic        log_ack;

  int n_total = 0;
  int n_pass  = 0;
  logic [15:0] coef_q [$];
  logic [15:0] log_q  [$];

  always #5 clk = ~clk;

  coefficient_window_subsystem dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .coef_wb_cyc_i(coef_cyc), .coef_wb_stb_i(coef_stb), .coef_wb_we_i(coef_we),
    .coef_wb_adr_i(coef_adr), .coef_wb_sel_i(2'b11), .coef_wb_dat_i(coef_dat_i),
    .coef_wb_dat_o(coef_dat_o), .coef_wb_ack_o(coef_ack),
    .log_wb_cyc_i(log_cyc), .log_wb_stb_i(log_stb), .log_wb_we_i(log_we),
    .log_wb_adr_i(log_adr), .log_wb_sel_i(2'b11), .log_wb_dat_i(log_dat_i),
    .log_wb_dat_o(log_dat_o), .log_wb_ack_o(log_ack)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One access on window w (0 = coefficient, 1 = logging), stb held for hold cycles.
  task automatic xfer(input int w, input logic we, input logic [15:0] adr,
                      input logic [15:0] dat, input logic [15:0] exp,
                      input int hold, input string tag);
    int          acks = 0;
    logic        ack_s;
    logic [15:0] dat_s;
    if (!we) begin
      if (w == 0) coef_q.push_back(exp);
      else        log_q.push_back(exp);
    end
    @(negedge clk);
    if (w == 0) begin
      coef_cyc = 1; coef_stb = 1; coef_we = we; coef_adr = adr; coef_dat_i = dat;
    end else begin
      log_cyc = 1; log_stb = 1; log_we = we; log_adr = adr; log_dat_i = dat;
    end
    for (int i = 0; i <= hold; i++) begin
      if (i == hold) begin
        if (w == 0) begin coef_cyc = 0; coef_stb = 0; end
        else        begin log_cyc = 0; log_stb = 0; end
      end
      @(negedge clk);
      ack_s = (w == 0) ? coef_ack : log_ack;
      dat_s = (w == 0) ? coef_dat_o : log_dat_o;
      if (ack_s) begin
        acks++;
        if (!we) begin
          if (w == 0 && coef_q.size() > 0)     check({tag, "_data"}, dat_s, coef_q.pop_front());
          else if (w == 1 && log_q.size() > 0) check({tag, "_data"}, dat_s, log_q.pop_front());
          else check({tag, "_unexpected_ack"}, 16'h0001, 16'h0000);
        end
      end
    end
    check({tag, "_ack_count"}, 16'(acks), 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_coef_ack", {15'd0, coef_ack}, 16'h0000);
    check("rst_log_ack", {15'd0, log_ack}, 16'h0000);
    check("rst_coef_dat", coef_dat_o, 16'h0000);
    check("rst_log_dat", log_dat_o, 16'h0000);
    rst_n = 1'b1;

    // Coefficient pointer and data writes
    xfer(0, 1, PTR,  16'h5555, 16'h0000, 1, "coef_wr_ptr");
    xfer(0, 0, PTR,  16'h0000, 16'h0555, 1, "coef_rd_ptr");
    xfer(0, 1, DATA, 16'hAAAA, 16'h0000, 2, "coef_wr_aaaa");
    xfer(0, 1, DATA, 16'hBBBB, 16'h0000, 2, "coef_wr_bbbb");
    xfer(0, 0, PTR,  16'h0000, 16'h0557, 1, "coef_ptr_after_wr");

    // Logging reads with auto-increment; logging data write is a no-op
    xfer(1, 1, PTR,  16'h5555, 16'h0000, 1, "log_wr_ptr");
    xfer(1, 0, DATA, 16'h0000, 16'hAAAA, 2, "log_rd_0");
    xfer(1, 0, DATA, 16'h0000, 16'hBBBB, 2, "log_rd_1");
    xfer(1, 0, PTR,  16'h0000, 16'h0557, 1, "log_ptr_after_rd");
    xfer(1, 1, DATA, 16'hFFFF, 16'h0000, 1, "log_wr_data");
    xfer(1, 0, PTR,  16'h0000, 16'h0557, 1, "log_ptr_after_wr");
    xfer(1, 1, PTR,  16'h0555, 16'h0000, 1, "log_wr_ptr2");
    xfer(1, 0, DATA, 16'h0000, 16'hAAAA, 1, "log_rd_unchanged");

    // Coefficient data read returns zero, no increment; unknown addresses are inert
    xfer(0, 0, DATA, 16'h0000, 16'h0000, 1, "coef_rd_data");
    xfer(0, 1, 16'h0010, 16'h0123, 16'h0000, 1, "coef_wr_other");
    xfer(0, 0, 16'h0010, 16'h0000, 16'h0000, 1, "coef_rd_other");
    xfer(0, 0, PTR,  16'h0000, 16'h0557, 1, "coef_ptr_unchanged");

    // Pointer wrap, with stb held for 5 cycles
    xfer(0, 1, PTR,  16'h07FF, 16'h0000, 1, "coef_wr_ptr_7ff");
    xfer(0, 1, DATA, 16'h1234, 16'h0000, 5, "coef_wr_wrap");
    xfer(0, 0, PTR,  16'h0000, 16'h0000, 1, "coef_ptr_wrapped");
    xfer(1, 1, PTR,  16'h07FF, 16'h0000, 1, "log_wr_ptr_7ff");
    xfer(1, 0, DATA, 16'h0000, 16'h1234, 5, "log_rd_7ff");
    xfer(1, 0, PTR,  16'h0000, 16'h0000, 1, "log_ptr_wrapped");

    // Concurrent write and read of the same address returns the old word
    xfer(0, 1, PTR,  16'h0020, 16'h0000, 1, "coef_ptr_20");
    xfer(0, 1, DATA, 16'h1111, 16'h0000, 1, "coef_wr_1111");
    xfer(0, 1, PTR,  16'h0020, 16'h0000, 1, "coef_ptr_20b");
    xfer(1, 1, PTR,  16'h0020, 16'h0000, 1, "log_ptr_20");
    fork
      xfer(0, 1, DATA, 16'hCAFE, 16'h0000, 1, "conc_wr");
      xfer(1, 0, DATA, 16'h0000, 16'h1111, 1, "conc_rd_old");
    join
    xfer(1, 1, PTR,  16'h0020, 16'h0000, 1, "log_ptr_20b");
    xfer(1, 0, DATA, 16'h0000, 16'hCAFE, 1, "rd_new");

    // Read one cycle after a same-address write sees the new word
    xfer(0, 1, PTR,  16'h0030, 16'h0000, 1, "coef_ptr_30");
    xfer(1, 1, PTR,  16'h0030, 16'h0000, 1, "log_ptr_30");
    fork
      xfer(0, 1, DATA, 16'hBEEF, 16'h0000, 1, "stag_wr");
      begin
        @(negedge clk);
        xfer(1, 0, DATA, 16'h0000, 16'hBEEF, 1, "stag_rd");
      end
    join

    // Reset during ACK of a data write aborts the access
    xfer(0, 1, PTR,  16'h0100, 16'h0000, 1, "coef_ptr_100");
    @(negedge clk);
    coef_cyc = 1; coef_stb = 1; coef_we = 1; coef_adr = DATA; coef_dat_i = 16'h7777;
    @(negedge clk);
    check("mid_ack_before_rst", {15'd0, coef_ack}, 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    check("mid_ack_after_rst", {15'd0, coef_ack}, 16'h0000);
    check("mid_coef_dat_rst", coef_dat_o, 16'h0000);
    check("mid_log_dat_rst", log_dat_o, 16'h0000);
    @(negedge clk);
    coef_cyc = 0; coef_stb = 0;
    rst_n = 1'b1;
    xfer(0, 0, PTR,  16'h0000, 16'h0000, 1, "coef_ptr_after_rst");
    xfer(1, 0, PTR,  16'h0000, 16'h0000, 1, "log_ptr_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
